interconexion_onchip_memory_dp: RTL

//  Parametrised true-dual-port on-chip RAM with two Avalon-MM slave ports: s1 for the Nios/CPU, s2 for the image-filter datapath.

---
 rtl/interconexion_onchip_memory_dp.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/interconexion_onchip_memory_dp.sv
// True-dual-port word RAM with two Avalon-MM slave ports (s1 = CPU, s2 = filter datapath).
// Pipelined reads with readdatavalid, byte-lane writes, and s1-priority arbitration of same-address writes.
module interconexion_onchip_memory_dp #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned READ_LATENCY = 1,
  parameter string       INIT_FILE    = ""
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic                    s1_waitrequest,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    s2_waitrequest
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
  localparam int unsigned NPORTS   = 2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Preloading from INIT_FILE is left to the target memory flow; plain RTL contents are undefined.
  if (INIT_FILE != "") begin : g_init_file_external
  end

  // Port-indexed views so both ports share one description (index 0 = s1, 1 = s2).
  logic [NPORTS-1:0]     sel;
  logic [NPORTS-1:0]     rd_req;
  logic [NPORTS-1:0]     wr_req;
  logic [ADDR_WIDTH-1:0] addr  [NPORTS];
  logic [BE_WIDTH-1:0]   be    [NPORTS];
  logic [DATA_WIDTH-1:0] wdata [NPORTS];

  assign sel      = {s2_chipselect, s1_chipselect};
  assign rd_req   = {s2_read, s1_read};
  assign wr_req   = {s2_write, s1_write};
  assign addr[0]  = s1_address;
  assign addr[1]  = s2_address;
  assign be[0]    = s1_byteenable;
  assign be[1]    = s2_byteenable;
  assign wdata[0] = s1_writedata;
  assign wdata[1] = s2_writedata;

  // Both ports writing the same word: s1 wins, s2 is stalled for the cycle.
  logic collision_c;
  assign collision_c = sel[0] & wr_req[0] & sel[1] & wr_req[1] & (addr[0] == addr[1]);

  assign s1_waitrequest = ~clken;
  assign s2_waitrequest = ~clken | (collision_c & ~reset);

  logic [NPORTS-1:0] stall_c;
  logic [NPORTS-1:0] wr_en_c;
  logic [NPORTS-1:0] rd_en_c;

  assign stall_c = {collision_c, 1'b0};

  // Accept qualification; write wins over a simultaneous read.
  always_comb begin
    wr_en_c = '0;
    rd_en_c = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (clken && !reset && sel[p] && !stall_c[p]) begin
        wr_en_c[p] = wr_req[p];
        rd_en_c[p] = rd_req[p] & ~wr_req[p];
      end
    end
  end

  // Byte-lane writes; accepted writes never target the same word on both ports.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NPORTS; p++) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (wr_en_c[p] && be[p][b]) begin
          mem[addr[p]][b*8 +: 8] <= wdata[p][b*8 +: 8];
        end
      end
    end
  end

  // First read stage samples the array before same-edge writes land, giving old-data reads.
  logic [NPORTS-1:0]     vld1;
  logic [DATA_WIDTH-1:0] data1 [NPORTS];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld1 <= '0;
      for (int p = 0; p < NPORTS; p++) begin
        data1[p] <= '0;
      end
    end else if (clken) begin
      vld1 <= rd_en_c;
      for (int p = 0; p < NPORTS; p++) begin
        if (rd_en_c[p]) begin
          data1[p] <= mem[addr[p]];
        end
      end
    end
  end

  logic [NPORTS-1:0]     vld_out;
  logic [DATA_WIDTH-1:0] data_out [NPORTS];

  if (READ_LATENCY >= 2) begin : g_out_reg
    always_ff @(posedge clk) begin
      if (reset) begin
        vld_out <= '0;
        for (int p = 0; p < NPORTS; p++) begin
          data_out[p] <= '0;
        end
      end else if (clken) begin
        vld_out <= vld1;
        for (int p = 0; p < NPORTS; p++) begin
          if (vld1[p]) begin
            data_out[p] <= data1[p];
          end
        end
      end
    end
  end else begin : g_out_direct
    assign vld_out     = vld1;
    assign data_out[0] = data1[0];
    assign data_out[1] = data1[1];
  end

  assign s1_readdata      = data_out[0];
  assign s2_readdata      = data_out[1];
  assign s1_readdatavalid = vld_out[0];
  assign s2_readdatavalid = vld_out[1];

endmodule
